// File: rtl/gnrc_stream_arb_mux.sv
// Round-robin N:1 stream merge with a registered output stage and source tagging.
// Define GNRC_STREAM_ARB_MUX_PKT_LOCK_EN to hold each grant until the packet's last beat.
module gnrc_stream_arb_mux #(
    parameter int  N     = 2,
    parameter type DTYPE = logic,
    parameter int  AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  DTYPE [N-1:0]     data_i,
    input  logic [N-1:0]     valid_i,
    input  logic [N-1:0]     last_i,
    output logic [N-1:0]     ready_o,
    output DTYPE             data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic [AW-1:0]    src_o,
    input  logic             ready_i
);

    logic [AW-1:0] r_ptr;
    logic          r_valid;
    logic          r_last;
    logic [AW-1:0] r_src;
    DTYPE          r_data;

    logic [AW-1:0] w_arb_idx;
    logic          w_arb_hit;
    logic          w_locked;
    logic [AW-1:0] w_lock_idx;
    logic [AW-1:0] w_gidx;
    logic          w_gvalid;
    logic          w_load_ok;
    logic          w_accept;
    logic          w_last_sel;
    logic          w_ptr_adv;
    logic [AW-1:0] w_ptr_inc;

    // Descending scan so the candidate closest to r_ptr (in rotating order) wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        w_arb_idx = r_ptr;
        w_arb_hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = AW'((int'(r_ptr) + k) % N);
            if (valid_i[idx]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = idx;
            end
        end
    end

    assign w_gidx     = w_locked ? w_lock_idx : w_arb_idx;
    assign w_gvalid   = (w_locked | w_arb_hit) & ~rst_i;
    assign w_load_ok  = ~r_valid | ready_i;
    assign w_last_sel = last_i[w_gidx];
    assign w_accept   = |(ready_o & valid_i);
    assign w_ptr_inc  = (w_gidx == AW'(N - 1)) ? '0 : w_gidx + AW'(1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign ready_o[gi] = w_gvalid & w_load_ok & (w_gidx == AW'(gi));
        end
    endgenerate

`ifdef GNRC_STREAM_ARB_MUX_PKT_LOCK_EN
    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_lidx;
    logic [AW-1:0] w_lidx_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_ARB;
            r_lidx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_lidx  <= w_lidx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lidx_next  = r_lidx;
        case (r_state)
            ST_ARB: begin
                if (w_accept && !w_last_sel) begin
                    w_state_next = ST_LOCKED;
                    w_lidx_next  = w_gidx;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_last_sel) begin
                    w_state_next = ST_ARB;
                end
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    assign w_locked   = (r_state == ST_LOCKED);
    assign w_lock_idx = r_lidx;
    assign w_ptr_adv  = w_accept & w_last_sel;
`else
    assign w_locked   = 1'b0;
    assign w_lock_idx = '0;
    assign w_ptr_adv  = w_accept;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_ptr_adv) begin
            r_ptr <= w_ptr_inc;
        end
    end

    // A pop with a simultaneous accept reloads; a pop alone only clears valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_src   <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_last  <= w_last_sel;
            r_src   <= w_gidx;
            r_data  <= data_i[w_gidx];
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign src_o   = r_src;

endmodule

// File: tb/tb_gnrc_stream_arb_mux.sv
// Bench for gnrc_stream_arb_mux (N=4, 8-bit data): directed scenarios then randomized
// traffic, all checked against a packet-level behavioural model.
module tb_gnrc_stream_arb_mux;

    localparam int N = 4;
    typedef logic [7:0] byte_t;

    logic          clk = 1'b0;
    logic          rst_i;
    byte_t [N-1:0] data_i;
    logic [N-1:0]  valid_i;
    logic [N-1:0]  last_i;
    logic [N-1:0]  ready_o;
    byte_t         data_o;
    logic          valid_o;
    logic          last_o;
    logic [1:0]    src_o;
    logic          ready_i;

    gnrc_stream_arb_mux #(.N(N), .DTYPE(byte_t)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .src_o   (src_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Per-port pending beats {last, data}; port p offers q[p][0] while en[p] is set.
    logic [8:0]  q [N][$];
    logic [N-1:0] en;
    logic [10:0] log_q[$];   // accepted beats as seen on the output: {src, last, data}

    // Behavioural model state
    int    m_ptr    = 0;
    bit    m_locked = 0;
    int    m_lidx   = 0;
    bit    m_ov     = 0;
    byte_t m_od     = '0;
    bit    m_ol     = 0;
    int    m_os     = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [10:0] log_at(int k);
        return (k < log_q.size()) ? log_q[k] : 11'h7FF;
    endfunction

    task automatic drive();
        logic [8:0] b;
        for (int p = 0; p < N; p++) begin
            if (en[p] && q[p].size() > 0) begin
                b          = q[p][0];
                valid_i[p] = 1'b1;
                data_i[p]  = b[7:0];
                last_i[p]  = b[8];
            end else begin
                valid_i[p] = 1'b0;
            end
        end
    endtask

    // One clock: check ready_o, advance the model on the edge, then check the output stage.
    task automatic cycle();
        bit           found;
        bit           load_ok;
        bit           acc;
        int           g;
        int           p;
        logic [N-1:0] exp_rdy;
        byte_t        d;
        bit           l;
        drive();
        #1;
        load_ok = !m_ov || ready_i;
        found   = 0;
        g       = 0;
        if (!rst_i) begin
            if (m_locked) begin
                found = 1;
                g     = m_lidx;
            end else begin
                for (int off = 0; off < N; off++) begin
                    p = (m_ptr + off) % N;
                    if (valid_i[p]) begin
                        found = 1;
                        g     = p;
                        break;
                    end
                end
            end
        end
        exp_rdy = (found && load_ok) ? (N'(1) << g) : '0;
        chk("ready_o", 32'(ready_o), 32'(exp_rdy));
        acc = found && load_ok && valid_i[g];
        d   = data_i[g];
        l   = last_i[g];
        @(posedge clk);
        if (rst_i) begin
            m_ptr = 0; m_locked = 0; m_lidx = 0;
            m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
            acc = 0;
        end else if (acc) begin
            m_ov = 1; m_od = d; m_ol = l; m_os = g;
`ifdef GNRC_STREAM_ARB_MUX_PKT_LOCK_EN
            if (!m_locked && !l) begin
                m_locked = 1;
                m_lidx   = g;
            end else if (m_locked && l) begin
                m_locked = 0;
            end
            if (l) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
            void'(q[g].pop_front());
        end else if (m_ov && ready_i) begin
            m_ov = 0;
        end
        #1;
        chk("valid_o", 32'(valid_o), 32'(m_ov));
        chk("data_o",  32'(data_o),  32'(m_od));
        chk("last_o",  32'(last_o),  32'(m_ol));
        chk("src_o",   32'(src_o),   32'(m_os));
        if (acc) log_q.push_back({src_o, last_o, data_o});
    endtask

    task automatic clear_all();
        for (int p = 0; p < N; p++) q[p].delete();
        log_q.delete();
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        repeat (2) cycle();
        rst_i = 1'b0;
        clear_all();
    endtask

    initial begin
        logic [10:0] e;
        logic [10:0] exp_seq [4];
        int          len;

        rst_i   = 1'b1;
        ready_i = 1'b1;
        en      = '1;
        valid_i = '0;
        last_i  = '0;
        data_i  = '0;

        // Reset held 3 cycles with every port valid, then first grant to port 0
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 3; k++) q[p].push_back({1'b1, 8'(p * 16 + k)});
        repeat (3) cycle();
        chk("rst_valid_o", 32'(valid_o), 32'(0));
        chk("rst_src_o",   32'(src_o),   32'(0));
        rst_i = 1'b0;

        // Fairness: single-beat packets on all ports
        repeat (8) cycle();
        for (int k = 0; k < 8; k++) begin
            e = log_at(k);
            chk("fair_src", 32'(e[10:9]), 32'(k % 4));
        end

        // Packet lock with a one-cycle gap on port 1 while port 2 stays valid
        reset_dut();
        q[1].push_back({1'b0, 8'h10});
        q[1].push_back({1'b0, 8'h11});
        q[1].push_back({1'b1, 8'h12});
        for (int k = 0; k < 4; k++) q[2].push_back({1'b1, 8'(8'h20 + k)});
        cycle();
        en[1] = 1'b0;
        cycle();
        en[1] = 1'b1;
        repeat (5) cycle();
`ifdef GNRC_STREAM_ARB_MUX_PKT_LOCK_EN
        exp_seq[0] = {2'd1, 1'b0, 8'h10};
        exp_seq[1] = {2'd1, 1'b0, 8'h11};
        exp_seq[2] = {2'd1, 1'b1, 8'h12};
        exp_seq[3] = {2'd2, 1'b1, 8'h20};
`else
        exp_seq[0] = {2'd1, 1'b0, 8'h10};
        exp_seq[1] = {2'd2, 1'b1, 8'h20};
        exp_seq[2] = {2'd1, 1'b0, 8'h11};
        exp_seq[3] = {2'd2, 1'b1, 8'h21};
`endif
        for (int k = 0; k < 4; k++) chk("lock_seq", 32'(log_at(k)), 32'(exp_seq[k]));

        // Back-pressure: one beat captured and held, reload on the pop cycle
        reset_dut();
        for (int k = 0; k < 3; k++) q[3].push_back({1'b1, 8'(8'h30 + k)});
        ready_i = 1'b0;
        repeat (5) cycle();
        chk("bp_data",  32'(data_o),  32'h30);
        chk("bp_src",   32'(src_o),   32'(3));
        chk("bp_ready", 32'(ready_o), 32'(0));
        ready_i = 1'b1;
        cycle();
        chk("bp_reload", 32'(data_o), 32'h31);
        chk("bp_count",  32'(log_q.size()), 32'(2));

        // Wrap-around: after a port-2 packet, port 3 precedes port 0
        reset_dut();
        q[2].push_back({1'b1, 8'h2A});
        cycle();
        q[0].push_back({1'b1, 8'h0A});
        q[3].push_back({1'b1, 8'h3A});
        repeat (2) cycle();
        exp_seq[0] = {2'd2, 1'b1, 8'h2A};
        exp_seq[1] = {2'd3, 1'b1, 8'h3A};
        exp_seq[2] = {2'd0, 1'b1, 8'h0A};
        for (int k = 0; k < 3; k++) chk("wrap_seq", 32'(log_at(k)), 32'(exp_seq[k]));

        // Two 2-beat packets on ports 0 and 1: interleaving depends on packet locking
        reset_dut();
        q[0].push_back({1'b0, 8'h01});
        q[0].push_back({1'b1, 8'h02});
        q[1].push_back({1'b0, 8'h11});
        q[1].push_back({1'b1, 8'h12});
        repeat (4) cycle();
`ifdef GNRC_STREAM_ARB_MUX_PKT_LOCK_EN
        exp_seq[0] = {2'd0, 1'b0, 8'h01};
        exp_seq[1] = {2'd0, 1'b1, 8'h02};
        exp_seq[2] = {2'd1, 1'b0, 8'h11};
        exp_seq[3] = {2'd1, 1'b1, 8'h12};
`else
        exp_seq[0] = {2'd0, 1'b0, 8'h01};
        exp_seq[1] = {2'd1, 1'b0, 8'h11};
        exp_seq[2] = {2'd0, 1'b1, 8'h02};
        exp_seq[3] = {2'd1, 1'b1, 8'h12};
`endif
        for (int k = 0; k < 4; k++) chk("pkt_seq", 32'(log_at(k)), 32'(exp_seq[k]));

        // Randomized traffic: gaps, back-pressure, variable packet lengths, rare resets
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (q[p].size() < 2) begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) q[p].push_back({(k == len - 1), 8'($urandom)});
                end
                en[p] = ($urandom % 4) != 0;
            end
            ready_i = ($urandom % 4) != 0;
            rst_i   = ($urandom % 97) == 0;
            cycle();
        end
        rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gnrc_stream_arb_mux.md
# gnrc_stream_arb_mux

Round-robin, packet-aware stream multiplexer merging N AXI-stream-like inputs into one registered output, tagging each beat with its source index. It is the consumer-side counterpart of `gnrc_stream_demux`: the destination stage of a demux fabric and the merge point for returning streams. A grant is held for a whole packet, delimited by `last`, so beats from different sources never interleave inside a packet.

## Interface
- `N`, 2 — number of input ports; must be >=1.
- `DTYPE`, logic — data type of each port.
- `AW`, (N>1)?$clog2(N):1 — source index width; auto-generated, do not override.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `data_i`  in  DTYPE[N-1:0]  input data per port.
- `valid_i`  in  [N-1:0]  input valid per port.
- `last_i`  in  [N-1:0]  final beat of a packet, per port.
- `ready_o`  out  [N-1:0]  input ready per port.
- `data_o`  out  DTYPE  output data, registered.
- `valid_o`  out  1  output valid, registered.
- `last_o`  out  1  output last, registered.
- `src_o`  out  AW  index of the input that produced the current output beat, registered.
- `ready_i`  in  1  output ready.

## Operation
- State: round-robin pointer `ptr` (AW bits), FSM {ARB, LOCKED}, locked index `lidx`, and a one-entry output register.
- Output register can load when `load_ok = !valid_o || ready_i`. This gives full throughput with back-pressure.
- ARB:
  - Grant goes to the first `i` with `valid_i[i]=1`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - With no valid input, there is no grant and all `ready_o` are 0.
- LOCKED:
  - Grant is fixed to `lidx` regardless of `valid_i`. Other inputs see `ready_o=0`, even while `lidx` is idle (bubble).
- `ready_o[g] = grant[g] & load_ok`. Every other bit is 0, so `ready_o` is one-hot or zero.
- Accept happens when `valid_i[g] & ready_o[g]`. On accept, next cycle: `data_o=data_i[g]`, `last_o=last_i[g]`, `src_o=g`, `valid_o=1`.
- Output pop with no accept (`valid_o & ready_i` without accept): `valid_o` goes to 0. The other output registers hold their values.
- Transitions:
  - ARB → LOCKED on accept with `last_i[g]=0`; `lidx<=g`.
  - LOCKED → ARB on accept with `last_i[lidx]=1`.
  - Accept with `last=1` in ARB stays in ARB (single-beat packet).
- Pointer update: `ptr <= (g==N-1) ? 0 : g+1` on every accept with `last_i[g]=1`. It is unchanged otherwise.
- Simultaneous pop and accept in the same cycle: the register reloads with the new beat and `valid_o` stays 1.
- Output stability: while `valid_o & !ready_i`, all outputs hold stable (AXI rule).
- Input-side assumption: inputs hold `data/last` stable while `valid & !ready`. The block does not check this.
- N=1: `src_o` is always 0, and `ready_o[0] = load_ok` whenever state permits.

## Timing
- Latency is 1 cycle, input accept to `valid_o`.
- Throughput is 1 beat/cycle sustained, including across packet boundaries. Re-arbitration takes effect combinationally in the cycle after the `last` accept.
- `ready_o` depends combinationally on `valid_i`, `ptr`, state, `valid_o` and `ready_i`. There is no combinational path from `data_i` to any output.
- Reset values: `valid_o=0`, `last_o=0`, `src_o=0`, `data_o='0`, `ptr=0`, state=ARB, `lidx=0`.
- `ready_o` is forced to all zeros while `rst_i=1`.
- Reset mid-packet drops the lock and any held output beat.

## Configuration
- Macro: `GNRC_STREAM_ARB_MUX_PKT_LOCK_EN`.
- Defined: packet locking as described above (ARB/LOCKED FSM).
- Undefined:
  - No FSM; arbitration happens every beat.
  - `ptr` advances past `g` on every accept, regardless of `last_i`.
  - `last_i` is still carried to `last_o` unchanged.
  - Packets from different sources may interleave.

## Test plan
Test plan for N=4, DTYPE=logic[7:0], macro defined unless stated.
- Reset: hold `rst_i` for 3 cycles with all `valid_i=4'hF` → `ready_o=0`, `valid_o=0`, `src_o=0` throughout. After release, the first grant goes to port 0.
- Fairness: all four ports send single-beat packets (`last=1`) continuously, `ready_i=1` → `src_o` sequence 0,1,2,3,0,… with `valid_o=1` every cycle.
- Packet lock: port 1 sends a 3-beat packet 0x10,0x11,0x12 (last on 0x12) while port 2 is continuously valid → output 0x10,0x11,0x12 from `src_o=1`, then port 2. Also insert a one-cycle `valid_i[1]` gap mid-packet → `ready_o[2]` stays 0 during the gap.
- Back-pressure: `ready_i=0` for 5 cycles with port 3 valid → exactly one beat captured; `data_o` and `src_o` stable; `ready_o[3]=0` after the first accept. On `ready_i=1`, the next beat loads in the same cycle as the pop.
- Wrap-around: `ptr` at 3 (after a port-2 packet ends), ports 0 and 3 valid → port 3 granted. After its `last`, port 0 granted.
- Macro undefined: ports 0 and 1 both send 2-beat packets → `src_o` 0,1,0,1 (interleaved), with `last_o` matching the per-port last pattern.
